// File: rtl/max_stream_reducer_pkg.sv
// Shared types and defaults for the streaming max/min reducer.
package max_pkg;

  localparam int MAX_WIDTH = 4;
  localparam int MAX_COUNT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Fallback for toolchains without $clog2.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/max_stream_reducer_cmp_sel.sv
// Compare-and-select cell; the swap point for approximate comparator netlists.
module max_cmp_sel #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] cand,
  input  logic             min_mode,
  output logic             take,
  output logic [WIDTH-1:0] next
);

  // Strict compares so the earliest index wins ties.
  always_comb begin
    take = min_mode ? (cand < cur) : (cand > cur);
    next = take ? cand : cur;
  end

endmodule

// File: rtl/max_stream_reducer.sv
// Reduces each valid/ready frame to max value, its index and word count.
// Build with MAX_STREAM_MIN_MODE_EN to add the per-frame min_mode input.
module max_stream_reducer
  import max_pkg::*;
#(
  parameter int WIDTH = MAX_WIDTH,
  parameter int COUNT = MAX_COUNT,
  parameter int IDXW  = $clog2(COUNT),
  parameter int CNTW  = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MAX_STREAM_MIN_MODE_EN
  input  logic             min_mode,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDXW-1:0]  out_idx,
  output logic [CNTW-1:0]  out_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] omax_q, omax_d;
  logic [IDXW-1:0]  oidx_q, oidx_d;
  logic [CNTW-1:0]  ocnt_q, ocnt_d;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic             frame_end;
  logic [CNTW-1:0]  cnt_inc;
  logic             take;
  logic [WIDTH-1:0] next_val;
  logic             mode_w;

`ifdef MAX_STREAM_MIN_MODE_EN
  logic             min_q, min_d;
  assign mode_w = min_q;
`else
  assign mode_w = 1'b0;
`endif

  max_cmp_sel #(
    .WIDTH(WIDTH)
  ) u_sel (
    .cur     (max_q),
    .cand    (in_data),
    .min_mode(mode_w),
    .take    (take),
    .next    (next_val)
  );

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    omax_d    = omax_q;
    oidx_d    = oidx_q;
    ocnt_d    = ocnt_q;
`ifdef MAX_STREAM_MIN_MODE_EN
    min_d     = min_q;
`endif
    accept    = in_valid && in_ready_q;
    cnt_inc   = cnt_q + CNTW'(1);
    frame_end = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          max_d     = in_data;
          idx_d     = '0;
          cnt_d     = CNTW'(1);
`ifdef MAX_STREAM_MIN_MODE_EN
          min_d     = min_mode;
`endif
          frame_end = in_last;
          state_d   = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          max_d     = next_val;
          idx_d     = take ? cnt_q[IDXW-1:0] : idx_q;
          cnt_d     = cnt_inc;
          // A frame may be cut silently at COUNT words.
          frame_end = in_last || (cnt_inc == CNTW'(COUNT));
          if (frame_end) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_end) begin
      omax_d = max_d;
      oidx_d = idx_d;
      ocnt_d = cnt_d;
    end
    in_ready_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      max_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      omax_q     <= '0;
      oidx_q     <= '0;
      ocnt_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      max_q      <= max_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      omax_q     <= omax_d;
      oidx_q     <= oidx_d;
      ocnt_q     <= ocnt_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef MAX_STREAM_MIN_MODE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) min_q <= 1'b0;
    else        min_q <= min_d;
  end
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == ST_HOLD);
  assign out_max   = omax_q;
  assign out_idx   = oidx_q;
  assign out_count = ocnt_q;

endmodule
